// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port crossbar switch arbiter.
package switch_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PTR_W     = 2;

    typedef logic [PTR_W-1:0]     p_type;
    typedef logic [NUM_PORTS-1:0] mask_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam mask_t MASK_NONE = '0;

    // True when two destination masks share at least one output port.
    function automatic logic mask_hit(input mask_t a, input mask_t b);
        return |(a & b);
    endfunction

endpackage

// File: rtl/rr_claim.sv
// Rotating scan over the ports: each eligible port claims its outputs unless
// an earlier port in the scan already holds any of them.
module rr_claim
    import switch_pkg::*;
(
    input  mask_t i_eligible,
    input  mask_t i_mask [NUM_PORTS],
    input  p_type i_rr_ptr,
    output mask_t o_selected,
    output p_type o_first,
    output mask_t o_claimed,
    output p_type o_src [NUM_PORTS]
);

    logic  w_found;
    p_type w_idx;

    always_comb begin
        o_selected = '0;
        o_first    = '0;
        o_claimed  = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            o_src[j] = '0;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = i_rr_ptr + PTR_W'(k);
            if (i_eligible[w_idx] && !mask_hit(i_mask[w_idx], o_claimed)) begin
                o_selected[w_idx] = 1'b1;
                o_claimed         = o_claimed | i_mask[w_idx];
                if (!w_found) begin
                    o_first = w_idx;
                    w_found = 1'b1;
                end
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (i_mask[w_idx][j]) begin
                        o_src[j] = w_idx;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/switch_arbiter.sv
// Crossbar arbiter top: registered grants/routing, round-robin pointer and
// saturating conflict counter around the rr_claim scan.
module switch_arbiter
    import switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] pkt_dst0,
    input  logic [NUM_PORTS-1:0] pkt_dst1,
    input  logic [NUM_PORTS-1:0] pkt_dst2,
    input  logic [NUM_PORTS-1:0] pkt_dst3,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     mux_select0,
    output logic [PTR_W-1:0]     mux_select1,
    output logic [PTR_W-1:0]     mux_select2,
    output logic [PTR_W-1:0]     mux_select3,
    output logic [NUM_PORTS-1:0] arb_active,
    output logic [CNT_W-1:0]     conflict_cnt
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_run;

    mask_t  r_grant;
    mask_t  r_active;
    p_type  r_mux [NUM_PORTS];
    p_type  r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;

    mask_t  w_mask [NUM_PORTS];
    mask_t  w_has_dst;
    mask_t  w_elig;
    mask_t  w_sel;
    mask_t  w_claimed;
    p_type  w_first;
    p_type  w_src [NUM_PORTS];

    assign w_mask[0] = pkt_dst0;
    assign w_mask[1] = pkt_dst1;
    assign w_mask[2] = pkt_dst2;
    assign w_mask[3] = pkt_dst3;

    // First cycle out of reset is held quiet so no grant follows deassertion directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_INIT: w_state_nxt = ST_RUN;
            ST_RUN:  w_run       = 1'b1;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_has_dst[i] = (w_mask[i] != MASK_NONE);
        end
    end

    // A port granted this cycle is transmitting; its req is stale until next cycle.
    assign w_elig = w_run ? (req & w_has_dst & ~r_grant) : '0;

    rr_claim u_rr_claim (
        .i_eligible (w_elig),
        .i_mask     (w_mask),
        .i_rr_ptr   (r_rr_ptr),
        .o_selected (w_sel),
        .o_first    (w_first),
        .o_claimed  (w_claimed),
        .o_src      (w_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_active <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_mux[j] <= '0;
            end
        end else begin
            r_grant  <= w_sel;
            r_active <= w_claimed;
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_mux[j] <= w_src[j];
            end
            if (|w_sel) begin
                r_rr_ptr <= w_first + PTR_W'(1);
            end
            if ((|(w_elig & ~w_sel)) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign grant        = r_grant;
    assign arb_active   = r_active;
    assign mux_select0  = r_mux[0];
    assign mux_select1  = r_mux[1];
    assign mux_select2  = r_mux[2];
    assign mux_select3  = r_mux[3];
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed self-checking bench for switch_arbiter.
module tb_switch_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3;
    logic [3:0] grant;
    logic [1:0] mux_select0, mux_select1, mux_select2, mux_select3;
    logic [3:0] arb_active;
    logic [7:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;

    switch_arbiter #(.NUM_PORTS(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .pkt_dst0     (pkt_dst0),
        .pkt_dst1     (pkt_dst1),
        .pkt_dst2     (pkt_dst2),
        .pkt_dst3     (pkt_dst3),
        .grant        (grant),
        .mux_select0  (mux_select0),
        .mux_select1  (mux_select1),
        .mux_select2  (mux_select2),
        .mux_select3  (mux_select3),
        .arb_active   (arb_active),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mux(input string tag, input logic [7:0] exp);
        chk(tag, 32'({mux_select3, mux_select2, mux_select1, mux_select0}), 32'(exp));
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        pkt_dst0 = 4'b0000;
        pkt_dst1 = 4'b0000;
        pkt_dst2 = 4'b0000;
        pkt_dst3 = 4'b0000;
        tick();
        tick();
        chk("rst_grant",  32'(grant),        32'h0);
        chk("rst_active", 32'(arb_active),   32'h0);
        chk("rst_cnt",    32'(conflict_cnt), 32'h0);
        chk_mux("rst_mux", 8'h00);
        rst_n = 1'b1;
        tick();

        // Scenario 1: single unicast, one-cycle pulse, stale req blocked
        req = 4'b0001; pkt_dst0 = 4'b0100;
        tick();
        chk("s1_grant",  32'(grant),      32'h1);
        chk("s1_active", 32'(arb_active), 32'h4);
        chk_mux("s1_mux", 8'h00);
        tick();
        chk("s1_grant_gap",  32'(grant),      32'h0);
        chk("s1_active_gap", 32'(arb_active), 32'h0);
        tick();
        chk("s1_grant_again", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        chk("s1_cnt", 32'(conflict_cnt), 32'h0);
        tick();

        // Scenario 2: disjoint masks granted together (ptr=1 -> 2)
        req = 4'b0011; pkt_dst0 = 4'b0001; pkt_dst1 = 4'b0010;
        tick();
        chk("s2_grant",  32'(grant),        32'h3);
        chk("s2_active", 32'(arb_active),   32'h3);
        chk_mux("s2_mux", 8'b00_00_01_00);
        chk("s2_cnt",    32'(conflict_cnt), 32'h0);
        req = 4'b0000;
        tick();
        // Port 3 alone: ptr 2 -> 0; mux_select0 carries source 3
        req = 4'b1000; pkt_dst3 = 4'b0001;
        tick();
        chk("p3_grant", 32'(grant), 32'h8);
        chk_mux("p3_mux", 8'b00_00_00_11);
        req = 4'b0000;
        tick();

        // Scenario 3: two ports fight for output 3, ptr=0
        req = 4'b0110; pkt_dst1 = 4'b1000; pkt_dst2 = 4'b1000;
        tick();
        chk("s3_grant",  32'(grant),        32'h2);
        chk("s3_active", 32'(arb_active),   32'h8);
        chk_mux("s3_mux", 8'b01_00_00_00);
        chk("s3_cnt",    32'(conflict_cnt), 32'h1);
        tick();
        chk("s3_grant2", 32'(grant),        32'h4);
        chk_mux("s3_mux2", 8'b10_00_00_00);
        chk("s3_cnt2",   32'(conflict_cnt), 32'h1);
        req = 4'b0000;
        tick();
        // ptr=3 -> port 3 alone brings it back to 0
        req = 4'b1000; pkt_dst3 = 4'b0001;
        tick();
        chk("p3b_grant", 32'(grant), 32'h8);
        req = 4'b0000;
        tick();

        // Scenario 4: broadcast from port 0 blocks everyone
        req = 4'b1111; pkt_dst0 = 4'b1111; pkt_dst1 = 4'b0010;
        pkt_dst2 = 4'b0100; pkt_dst3 = 4'b1000;
        tick();
        chk("s4_grant",  32'(grant),        32'h1);
        chk("s4_active", 32'(arb_active),   32'hF);
        chk_mux("s4_mux", 8'h00);
        chk("s4_cnt",    32'(conflict_cnt), 32'h2);
        req = 4'b0000;
        tick();

        // Scenario 5: empty mask never granted, no conflict
        req = 4'b0100; pkt_dst2 = 4'b0000;
        tick();
        chk("s5_grant",  32'(grant),        32'h0);
        chk("s5_active", 32'(arb_active),   32'h0);
        tick();
        chk("s5_grant2", 32'(grant),        32'h0);
        chk("s5_cnt",    32'(conflict_cnt), 32'h2);

        // Three ports on output 3: one conflict every cycle
        req = 4'b1110; pkt_dst1 = 4'b1000; pkt_dst2 = 4'b1000; pkt_dst3 = 4'b1000;
        repeat (252) tick();
        chk("sat_254", 32'(conflict_cnt), 32'hFE);
        tick();
        chk("sat_255", 32'(conflict_cnt), 32'hFF);
        repeat (47) tick();
        chk("sat_hold", 32'(conflict_cnt), 32'hFF);
        req = 4'b0000;
        tick();
        tick();

        // Scenario 6: reset asserted while a grant is out
        req = 4'b0001; pkt_dst0 = 4'b0100;
        tick();
        chk("s6_pre_grant", 32'(grant), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("s6_async_grant",  32'(grant),        32'h0);
        chk("s6_async_active", 32'(arb_active),   32'h0);
        chk("s6_async_cnt",    32'(conflict_cnt), 32'h0);
        req = 4'b0011; pkt_dst0 = 4'b0001; pkt_dst1 = 4'b0001;
        tick();
        chk("s6_hold_grant", 32'(grant), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("s6_first_edge", 32'(grant), 32'h0);
        tick();
        chk("s6_ptr0_grant", 32'(grant),        32'h1);
        chk("s6_cnt",        32'(conflict_cnt), 32'h1);
        req = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
